// File: rtl/rr_arbiter_quantum.sv
`default_nettype none
// =============================================================================
// Module   : rr_arbiter_quantum
// Purpose  : Round-robin arbiter with a per-channel grant quantum and a
//            registered one-hot grant that hands over with no dead cycles.
// Revision : 1.0 - initial release
// =============================================================================
module rr_arbiter_quantum #(
   parameter int N   = 4,
   parameter int QW  = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*QW-1:0] quantum,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IDW-1:0]  gnt_id,
   output logic            expire
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t         r_state,  w_state_nxt;
   logic [IDW-1:0] r_ptr,    w_ptr_nxt;
   logic [QW-1:0]  r_cnt,    w_cnt_nxt;
   logic [QW-1:0]  r_qlat,   w_qlat_nxt;
   logic [N-1:0]   r_gnt,    w_gnt_nxt;
   logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;

   logic [2*N-1:0] w_req2;
   logic [N-1:0]   w_rot;
   logic [IDW-1:0] w_off;
   logic [IDW:0]   w_sum;
   logic [IDW-1:0] w_win;
   logic           w_found;
   logic [QW-1:0]  w_win_q;
   logic           w_owner_req;
   logic           w_last;
   logic           w_release;

   // Rotate requests so the pointer channel sits at bit 0; the lowest set bit
   // of the rotated vector is the winner's offset from the pointer.
   assign w_req2  = {req, req};
   assign w_rot   = N'(w_req2 >> r_ptr);
   assign w_found = |req;

   always_comb begin
      w_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = IDW'(i);
      end
   end

   assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_win = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N)) : IDW'(w_sum);

   always_comb begin
      w_win_q = '0;
      for (int i = 0; i < N; i++) begin
         if (w_win == IDW'(i)) w_win_q = quantum[i*QW +: QW];
      end
   end

   // gnt is one-hot or zero, so masking req with it yields the owner's request.
   assign w_owner_req = |(req & r_gnt);
   assign w_last      = (r_cnt == (r_qlat - QW'(1)));
   assign w_release   = (r_state == S_IDLE) || !w_owner_req || w_last;

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_cnt_nxt    = r_cnt;
      w_qlat_nxt   = r_qlat;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      if (!w_release) begin
         w_cnt_nxt = r_cnt + QW'(1);
      end else if (w_found) begin
         w_state_nxt  = S_BUSY;
         w_gnt_nxt    = N'(1) << w_win;
         w_gnt_id_nxt = w_win;
         w_cnt_nxt    = '0;
         w_qlat_nxt   = (w_win_q == '0) ? QW'(1) : w_win_q;
         w_ptr_nxt    = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
      end else begin
         w_state_nxt = S_IDLE;
         w_gnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_qlat   <= QW'(1);
         r_gnt    <= '0;
         r_gnt_id <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_qlat   <= w_qlat_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = |r_gnt;
   assign gnt_id    = r_gnt_id;
   assign expire    = (r_state == S_BUSY) && w_owner_req && w_last;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_quantum.sv
`default_nettype none
// =============================================================================
// Module   : tb_rr_arbiter_quantum
// Purpose  : Self-checking bench: directed vector table, random run against a
//            behavioural model, and a pointer-wrap sequence on an 8-channel build.
// Revision : 1.0 - initial release
// =============================================================================
module tb_rr_arbiter_quantum;

   localparam int N     = 4;
   localparam int QW    = 4;
   localparam int IDW   = 2;
   localparam int BOUND = (N - 1) * ((1 << QW) - 1) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*QW-1:0] quantum;
   logic [N-1:0]    gnt;
   logic            gnt_valid;
   logic [IDW-1:0]  gnt_id;
   logic            expire;

   logic            rst8;
   logic [7:0]      req8;
   logic [31:0]     quantum8;
   logic [7:0]      gnt8;
   logic            gnt_valid8;
   logic [2:0]      gnt_id8;
   logic            expire8;

   always #5 clk = ~clk;

   rr_arbiter_quantum #(.N(N), .QW(QW)) dut (
      .clk(clk), .rst(rst), .req(req), .quantum(quantum),
      .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .expire(expire)
   );

   rr_arbiter_quantum #(.N(8), .QW(4)) dut8 (
      .clk(clk), .rst(rst8), .req(req8), .quantum(quantum8),
      .gnt(gnt8), .gnt_valid(gnt_valid8), .gnt_id(gnt_id8), .expire(expire8)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: owner index (-1 when idle), cycles used so far,
   // quantum captured at grant start, and next-priority channel.
   int m_owner = -1;
   int m_used  = 0;
   int m_lim   = 1;
   int m_ptr   = 0;
   int m_id    = 0;

   function automatic int quantum_of(input logic [N*QW-1:0] q, input int ch);
      int v;
      v = int'((q >> (ch * QW)) & ((1 << QW) - 1));
      return (v == 0) ? 1 : v;
   endfunction

   function automatic logic bit_of(input logic [N-1:0] v, input int idx);
      return 1'(v >> idx);
   endfunction

   function automatic logic model_expire(input logic [N-1:0] rq);
      return (m_owner >= 0) && bit_of(rq, m_owner) && (m_used == m_lim);
   endfunction

   function automatic logic [N-1:0] model_gnt();
      return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
   endfunction

   task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N*QW-1:0] q);
      int w;
      if (r) begin
         m_owner = -1; m_used = 0; m_lim = 1; m_ptr = 0; m_id = 0;
      end else if (m_owner >= 0 && bit_of(rq, m_owner) && m_used < m_lim) begin
         m_used++;
      end else begin
         w = -1;
         for (int j = 0; j < N; j++) begin
            if (w < 0 && bit_of(rq, (m_ptr + j) % N)) w = (m_ptr + j) % N;
         end
         if (w >= 0) begin
            m_owner = w; m_used = 1; m_lim = quantum_of(q, w);
            m_ptr = (w + 1) % N; m_id = w;
         end else begin
            m_owner = -1;
         end
      end
   endtask

   logic         s_expire;
   logic [N-1:0] s_gnt_now;
   logic         m_expire_pre;

   // One clock: drive inputs, sample same-cycle outputs, step the model,
   // then land on the following falling edge where registered outputs are read.
   task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N*QW-1:0] q);
      rst = r; req = rq; quantum = q;
      #1;
      s_expire     = expire;
      s_gnt_now    = gnt;
      m_expire_pre = model_expire(rq);
      model_step(r, rq, q);
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic            rst;
      logic [N-1:0]    req;
      logic [N*QW-1:0] q;
      logic            exp_expire;
      logic [N-1:0]    exp_gnt;
      logic [IDW-1:0]  exp_id;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [N-1:0] rq, input logic [N*QW-1:0] q,
                               input logic ex, input logic [N-1:0] g, input logic [IDW-1:0] id);
      vec_t v;
      v.rst = r; v.req = rq; v.q = q; v.exp_expire = ex; v.exp_gnt = g; v.exp_id = id;
      vecs.push_back(v);
   endfunction

   initial begin
      logic [N-1:0]    rq;
      logic [N*QW-1:0] qv;
      logic            r;
      int              wt [N];
      int              max_wait;

      rst8 = 1'b1; req8 = '0; quantum8 = 32'h1111_1111;

      // equal quanta of 3, all requesting
      for (int i = 0; i < 3; i++) add(0, 4'hF, 16'h3333, 0, 4'b0001, 0);
      add(0, 4'hF, 16'h3333, 1, 4'b0010, 1);
      for (int i = 0; i < 2; i++) add(0, 4'hF, 16'h3333, 0, 4'b0010, 1);
      add(0, 4'hF, 16'h3333, 1, 4'b0100, 2);
      for (int i = 0; i < 2; i++) add(0, 4'hF, 16'h3333, 0, 4'b0100, 2);
      add(0, 4'hF, 16'h3333, 1, 4'b1000, 3);
      for (int i = 0; i < 2; i++) add(0, 4'hF, 16'h3333, 0, 4'b1000, 3);
      add(0, 4'hF, 16'h3333, 1, 4'b0001, 0);
      // quanta {1,4,2,0}
      add(1, 4'hF, 16'h1420, 0, 4'b0000, 0);
      add(0, 4'hF, 16'h1420, 0, 4'b0001, 0);
      add(0, 4'hF, 16'h1420, 1, 4'b0010, 1);
      add(0, 4'hF, 16'h1420, 0, 4'b0010, 1);
      add(0, 4'hF, 16'h1420, 1, 4'b0100, 2);
      for (int i = 0; i < 3; i++) add(0, 4'hF, 16'h1420, 0, 4'b0100, 2);
      add(0, 4'hF, 16'h1420, 1, 4'b1000, 3);
      add(0, 4'hF, 16'h1420, 1, 4'b0001, 0);
      // sole requester ch2, quantum 2
      add(1, 4'b0100, 16'h2222, 0, 4'b0000, 0);
      add(0, 4'b0100, 16'h2222, 0, 4'b0100, 2);
      for (int i = 0; i < 3; i++) begin
         add(0, 4'b0100, 16'h2222, 0, 4'b0100, 2);
         add(0, 4'b0100, 16'h2222, 1, 4'b0100, 2);
      end
      add(0, 4'b0000, 16'h2222, 0, 4'b0000, 2);
      add(0, 4'b0000, 16'h2222, 0, 4'b0000, 2);
      // owner drops request, ch3 takes over with no gap
      add(1, 4'b0000, 16'h5555, 0, 4'b0000, 0);
      add(0, 4'b0001, 16'h5555, 0, 4'b0001, 0);
      add(0, 4'b1001, 16'h5555, 0, 4'b0001, 0);
      add(0, 4'b1000, 16'h5555, 0, 4'b1000, 3);
      add(0, 4'b1000, 16'h5555, 0, 4'b1000, 3);
      // reset in the middle of ch1's grant
      add(1, 4'hF, 16'h3333, 0, 4'b0000, 0);
      for (int i = 0; i < 3; i++) add(0, 4'hF, 16'h3333, 0, 4'b0001, 0);
      add(0, 4'hF, 16'h3333, 1, 4'b0010, 1);
      add(1, 4'hF, 16'h3333, 0, 4'b0000, 0);
      add(1, 4'hF, 16'h3333, 0, 4'b0000, 0);
      add(0, 4'hF, 16'h3333, 0, 4'b0001, 0);

      // reset with requests present: nothing granted
      cycle(1, 4'hF, 16'h3333);
      cycle(1, 4'hF, 16'h3333);
      check("rst_gnt", gnt, 0);
      check("rst_valid", gnt_valid, 0);
      check("rst_id", gnt_id, 0);
      check("rst_expire", s_expire, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].req, vecs[i].q);
         check($sformatf("vec%0d_expire", i), s_expire, vecs[i].exp_expire);
         check($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp_gnt);
         check($sformatf("vec%0d_valid", i), gnt_valid, |vecs[i].exp_gnt);
         check($sformatf("vec%0d_id", i), gnt_id, vecs[i].exp_id);
      end

      rq = 4'hF; qv = 16'h3333; max_wait = 0;
      for (int b = 0; b < N; b++) wt[b] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 9) == 0) rq = rq ^ (N'(1) << b);
         end
         if ($urandom_range(0, 63) == 0) qv = (N*QW)'($urandom);
         r = ($urandom_range(0, 999) == 0);
         cycle(r, rq, qv);
         check($sformatf("rnd%0d_expire", c), s_expire, m_expire_pre);
         check($sformatf("rnd%0d_gnt", c), gnt, model_gnt());
         check($sformatf("rnd%0d_valid", c), gnt_valid, (m_owner >= 0));
         check($sformatf("rnd%0d_id", c), gnt_id, m_id);
         check($sformatf("rnd%0d_onehot", c), $onehot0(gnt), 1);
         for (int b = 0; b < N; b++) begin
            if (!r && bit_of(rq, b) && !bit_of(s_gnt_now, b)) wt[b]++;
            else wt[b] = 0;
            if (wt[b] > max_wait) max_wait = wt[b];
         end
      end
      check("rnd_wait_bound", (max_wait <= BOUND), 1);

      // 8-channel build: pointer wraps from ch7 back to ch0
      @(negedge clk);
      rst8 = 1'b1; req8 = 8'h00;
      @(posedge clk); @(negedge clk);
      check("w8_reset", gnt8, 8'h00);
      rst8 = 1'b0; req8 = 8'h80;
      @(posedge clk); @(negedge clk);
      check("w8_ch7", gnt8, 8'h80);
      check("w8_ch7_id", gnt_id8, 7);
      req8 = 8'h81;
      @(posedge clk); @(negedge clk);
      check("w8_wrap", gnt8, 8'h01);
      check("w8_wrap_id", gnt_id8, 0);
      @(posedge clk); @(negedge clk);
      check("w8_back", gnt8, 8'h80);
      check("w8_valid", gnt_valid8, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
